// File: rtl/tx_frame_arbiter.sv
// rtl/tx_frame_arbiter.sv - per-frame arbiter for the shared Ethernet TX path; define TX_ARB_FIXED_PRIO_EN for fixed priority
module tx_frame_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 96,
    parameter int LEN_W  = 16,
    localparam int GW    = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [N_REQ-1:0][LEN_W-1:0]   req_len,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ-1:0][7:0]         src_data,
    input  logic [N_REQ-1:0]              src_valid,
    output logic [N_REQ-1:0]              src_ready,
    output logic [ADDR_W-1:0]             header_addr,
    output logic [LEN_W-1:0]              number_of_bytes,
    output logic                          rx_header_valid,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          btx_full,
    input  logic                          tvalid,
    input  logic                          tready,
    input  logic                          tlast,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy,
    output logic                          drop_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        DRAIN
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [LEN_W-1:0]   remaining;
    logic [GW-1:0]      winner;
    logic               last_beat;

    // The transmitter's final output beat is what frees the shared path.
    assign last_beat = tvalid & tready & tlast;
    assign busy      = (state != IDLE);

`ifdef TX_ARB_FIXED_PRIO_EN
    // Lowest-index pending requester wins.
    always_comb begin
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (|(req_valid & (N_REQ'(1) << k))) winner = GW'(k);
        end
    end
`else
    logic [GW-1:0]    rr_ptr;
    logic [GW-1:0]    next_owner;
    logic [N_REQ-1:0] upper_req;

    // Requesters at or above the pointer get first chance; wrap to the bottom otherwise.
    assign upper_req  = req_valid & ~((N_REQ'(1) << rr_ptr) - N_REQ'(1));
    assign next_owner = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + GW'(1);

    // Round-robin pick: lowest set bit of the upper set, else lowest set bit overall.
    always_comb begin
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (|(req_valid & (N_REQ'(1) << k))) winner = GW'(k);
        end
        if (|upper_req) begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                if (|(upper_req & (N_REQ'(1) << k))) winner = GW'(k);
            end
        end
    end

    // Pointer moves past the owner when its frame is dropped or fully sent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if ((state == HDR && remaining == '0) || (state == DRAIN && last_beat)) begin
            rr_ptr <= next_owner;
        end
    end
`endif

    // Next state and the owner-steered strobes and payload path.
    always_comb begin
        state_next      = state;
        req_ready       = '0;
        src_ready       = '0;
        rx_header_valid = 1'b0;
        drop_pulse      = 1'b0;
        tx_valid        = 1'b0;
        tx_data         = '0;
        case (state)
            IDLE: begin
                if (|req_valid) state_next = HDR;
            end
            HDR: begin
                req_ready = N_REQ'(1) << grant_id;
                if (remaining == '0) begin
                    drop_pulse = 1'b1;
                    state_next = IDLE;
                end else begin
                    rx_header_valid = 1'b1;
                    state_next      = PAYLOAD;
                end
            end
            PAYLOAD: begin
                tx_data = src_data[grant_id];
                if (!btx_full && remaining != '0) begin
                    src_ready = N_REQ'(1) << grant_id;
                    tx_valid  = src_valid[grant_id];
                end
                if (tx_valid && remaining == LEN_W'(1)) state_next = DRAIN;
            end
            DRAIN: begin
                if (last_beat) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, grant capture and the byte countdown; the countdown only moves on a real write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            grant_id        <= '0;
            remaining       <= '0;
            header_addr     <= '0;
            number_of_bytes <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && |req_valid) begin
                grant_id        <= winner;
                header_addr     <= req_addr[winner];
                number_of_bytes <= req_len[winner];
                remaining       <= req_len[winner];
            end
            if (tx_valid && remaining != '0) remaining <= remaining - LEN_W'(1);
        end
    end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb/tb_tx_frame_arbiter.sv - randomized and directed bench for tx_frame_arbiter with a frame-level reference model
module tb_tx_frame_arbiter;

    localparam int N  = 2;
    localparam int AW = 96;
    localparam int LW = 16;
    localparam int GW = 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0][AW-1:0] req_addr;
    logic [N-1:0][LW-1:0] req_len;
    logic [N-1:0]        req_ready;
    logic [N-1:0][7:0]   src_data;
    logic [N-1:0]        src_valid;
    logic [N-1:0]        src_ready;
    logic [AW-1:0]       header_addr;
    logic [LW-1:0]       number_of_bytes;
    logic                rx_header_valid;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                btx_full;
    logic                tvalid, tready, tlast;
    logic [GW-1:0]       grant_id;
    logic                busy;
    logic                drop_pulse;

    always #5 clk = ~clk;

    tx_frame_arbiter #(.N_REQ(N), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .header_addr(header_addr), .number_of_bytes(number_of_bytes), .rx_header_valid(rx_header_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .btx_full(btx_full),
        .tvalid(tvalid), .tready(tready), .tlast(tlast),
        .grant_id(grant_id), .busy(busy), .drop_pulse(drop_pulse)
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            len;
        logic [7:0]    base;
    } frame_t;

    // Requester side: pending headers, and the frame currently being streamed.
    frame_t pend [N][$];
    frame_t cur [N];
    int     pos [N];
    bit     act [N];

    // Reference model: frame phase (0 idle, 1 header, 2 payload, 3 drain).
    int            m_phase, m_owner, m_left, m_nob, m_ptr;
    logic [AW-1:0] m_addr;
    int            drain_cnt;

    // Stimulus knobs.
    bit rnd;
    int bp_after, bp_rem, drain_delay;

    // Logs of what the DUT produced.
    int         cyc;
    int         hdr_cyc[$];
    int         grant_log[$];
    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    int         tx_cnt, drop_cnt;

    // Snapshot of the last sampled outputs.
    logic          s_busy, s_rxhv, s_txv, s_drop;
    logic [GW-1:0] s_grant;
    logic [AW-1:0] s_haddr;
    logic [LW-1:0] s_nob;
    logic [N-1:0]  s_sr, s_rr;

    int n_chk, n_pass;

    task automatic chk(input string nm, input logic [127:0] act_v, input logic [127:0] exp_v);
        n_chk++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act_v, exp_v);
    endtask

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < N; i++) if (pend[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    function automatic int pick();
        int w;
        bit found;
        w = 0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
`ifdef TX_ARB_FIXED_PRIO_EN
            if (!found && pend[k].size() != 0) begin w = k; found = 1'b1; end
`else
            if (!found && pend[(m_ptr + k) % N].size() != 0) begin w = (m_ptr + k) % N; found = 1'b1; end
`endif
        end
        return w;
    endfunction

    task automatic drive_req();
        for (int i = 0; i < N; i++) begin
            if (pend[i].size() != 0) begin
                req_valid[GW'(i)] = 1'b1;
                req_addr[GW'(i)]  = pend[i][0].addr;
                req_len[GW'(i)]   = LW'(pend[i][0].len);
            end else begin
                req_valid[GW'(i)] = 1'b0;
                req_addr[GW'(i)]  = '0;
                req_len[GW'(i)]   = '0;
            end
        end
    endtask

    task automatic drive_inputs();
        logic [2:0] t3;
        drive_req();
        for (int i = 0; i < N; i++) begin
            src_valid[GW'(i)] = act[i] && (rnd ? ($urandom_range(3) != 0) : 1'b1);
            src_data[GW'(i)]  = act[i] ? 8'(int'(cur[i].base) + pos[i]) : 8'($urandom);
        end
        if (rnd) btx_full = ($urandom_range(3) == 0);
        else if (m_phase == 2 && (m_nob - m_left) == bp_after && bp_rem > 0) begin
            btx_full = 1'b1;
            bp_rem--;
        end else btx_full = 1'b0;
        if (m_phase == 3 && drain_cnt == 0) begin
            {tvalid, tready, tlast} = 3'b111;
        end else begin
            if (m_phase == 3) drain_cnt--;
            if (rnd) begin
                t3 = 3'($urandom);
                if (t3 == 3'b111) t3 = 3'b110;
                {tvalid, tready, tlast} = t3;
            end else {tvalid, tready, tlast} = 3'b000;
        end
    endtask

    task automatic push(input int r, input logic [AW-1:0] a, input int len, input logic [7:0] b);
        frame_t f;
        f.addr = a;
        f.len  = len;
        f.base = b;
        pend[r].push_back(f);
        drive_req();
    endtask

    // One clock: compare outputs against the model mid-cycle, then advance the model at the edge.
    task automatic tick();
        logic [N-1:0] e_rr, e_sr;
        logic         e_hdr, e_drop, e_tx, beat;
        logic [7:0]   e_data;
        frame_t       f;
        @(negedge clk);
        e_rr = '0; e_sr = '0; e_hdr = 1'b0; e_drop = 1'b0; e_tx = 1'b0; e_data = '0;
        if (m_phase == 1) begin
            e_rr   = N'(1) << m_owner;
            e_hdr  = (m_left != 0);
            e_drop = (m_left == 0);
        end
        if (m_phase == 2 && !btx_full && m_left != 0) begin
            e_sr   = N'(1) << m_owner;
            e_tx   = src_valid[GW'(m_owner)];
            e_data = 8'(int'(cur[m_owner].base) + pos[m_owner]);
        end
        beat = tvalid & tready & tlast;
        chk("busy", busy, m_phase != 0);
        chk("grant_id", grant_id, m_owner);
        chk("header_addr", header_addr, m_addr);
        chk("number_of_bytes", number_of_bytes, m_nob);
        chk("req_ready", req_ready, e_rr);
        chk("rx_header_valid", rx_header_valid, e_hdr);
        chk("drop_pulse", drop_pulse, e_drop);
        chk("src_ready", src_ready, e_sr);
        chk("tx_valid", tx_valid, e_tx);
        if (e_tx) chk("tx_data", tx_data, e_data);
        s_busy = busy; s_rxhv = rx_header_valid; s_txv = tx_valid; s_drop = drop_pulse;
        s_grant = grant_id; s_haddr = header_addr; s_nob = number_of_bytes; s_sr = src_ready; s_rr = req_ready;
        if (rx_header_valid) hdr_cyc.push_back(cyc);
        if (|req_ready) grant_log.push_back(int'(grant_id));
        if (tx_valid) begin tx_cnt++; tx_log.push_back(tx_data); tx_cyc.push_back(cyc); end
        if (drop_pulse) drop_cnt++;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_phase = 0; m_owner = 0; m_left = 0; m_nob = 0; m_ptr = 0; m_addr = '0;
            for (int i = 0; i < N; i++) act[i] = 1'b0;
        end else begin
            case (m_phase)
                0: if (!all_empty()) begin
                    m_owner = pick();
                    m_addr  = pend[m_owner][0].addr;
                    m_nob   = pend[m_owner][0].len;
                    m_left  = m_nob;
                    m_phase = 1;
                end
                1: begin
                    f = pend[m_owner].pop_front();
                    if (m_left == 0) begin
                        m_phase = 0;
                        m_ptr   = (m_owner + 1) % N;
                    end else begin
                        cur[m_owner] = f;
                        pos[m_owner] = 0;
                        act[m_owner] = 1'b1;
                        m_phase      = 2;
                    end
                end
                2: if (e_tx) begin
                    pos[m_owner]++;
                    m_left--;
                    if (m_left == 0) begin
                        act[m_owner] = 1'b0;
                        m_phase      = 3;
                        drain_cnt    = rnd ? $urandom_range(3) : drain_delay;
                    end
                end
                3: if (beat) begin
                    m_phase = 0;
                    m_ptr   = (m_owner + 1) % N;
                end
                default: m_phase = 0;
            endcase
        end
        #1;
        drive_inputs();
    endtask

    task automatic run_idle(input int maxc, input string nm);
        int n;
        n = 0;
        while (!(m_phase == 0 && all_empty()) && n < maxc) begin tick(); n++; end
        chk({nm, "_completed"}, (m_phase == 0 && all_empty()), 1'b1);
        tick();
    endtask

    int t0, h0, g0, d0, rc, n, sum, zlen, r, len, k;
    int exp_g[4];

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; tx_cnt = 0; drop_cnt = 0;
        m_phase = 0; m_owner = 0; m_left = 0; m_nob = 0; m_ptr = 0; m_addr = '0; drain_cnt = 0;
        rnd = 1'b0; bp_after = -1; bp_rem = 0; drain_delay = 1;
        rst_n = 1'b0;
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        tick();
        chk("reset_busy", s_busy, 1'b0);
        chk("reset_grant_id", s_grant, 0);
        chk("reset_header_addr", s_haddr, 0);
        chk("reset_number_of_bytes", s_nob, 0);
        chk("reset_strobes", {s_rxhv, s_txv, s_drop, s_sr, s_rr}, 0);
        rst_n = 1'b1;
        tick();

        // Single frame, requester 0, four bytes A0..A3.
        t0 = tx_log.size(); h0 = hdr_cyc.size();
        push(0, 96'h0000_1111_2222_3333_4444_5555, 4, 8'hA0);
        rc = cyc;
        run_idle(50, "single");
        chk("single_hdr_count", hdr_cyc.size() - h0, 1);
        if (hdr_cyc.size() > h0) chk("single_hdr_latency", hdr_cyc[h0] - rc, 1);
        chk("single_writes", tx_log.size() - t0, 4);
        if (tx_log.size() >= t0 + 4) begin
            for (int i = 0; i < 4; i++) chk("single_byte", tx_log[t0 + i], 8'hA0 + 8'(i));
            chk("single_first_byte_latency", tx_cyc[t0] - hdr_cyc[h0], 1);
            chk("single_contiguous", tx_cyc[t0 + 3] - tx_cyc[t0], 3);
        end
        chk("single_idle_after", s_busy, 1'b0);

        // Back-pressure: six bytes, transmitter full for three cycles after byte 2.
        t0 = tx_log.size();
        bp_after = 2; bp_rem = 3;
        push(1, 96'hB, 6, 8'hB0);
        run_idle(60, "backpressure");
        bp_after = -1;
        chk("bp_writes", tx_log.size() - t0, 6);
        if (tx_log.size() >= t0 + 6) begin
            for (int i = 0; i < 6; i++) chk("bp_byte", tx_log[t0 + i], 8'hB0 + 8'(i));
            chk("bp_stall_gap", tx_cyc[t0 + 2] - tx_cyc[t0 + 1], 4);
            chk("bp_span", tx_cyc[t0 + 5] - tx_cyc[t0], 8);
        end

        // Contention: both requesters hold two 2-byte frames.
        g0 = grant_log.size(); h0 = hdr_cyc.size();
        push(0, 96'hC0, 2, 8'hC0);
        push(1, 96'hD0, 2, 8'hD0);
        push(0, 96'hC8, 2, 8'hC8);
        push(1, 96'hD8, 2, 8'hD8);
        run_idle(100, "contention");
`ifdef TX_ARB_FIXED_PRIO_EN
        exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 1; exp_g[3] = 1;
`else
        exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
`endif
        chk("contention_grants", grant_log.size() - g0, 4);
        if (grant_log.size() >= g0 + 4) begin
            for (int i = 0; i < 4; i++) chk("contention_order", grant_log[g0 + i], exp_g[i]);
        end
        if (hdr_cyc.size() >= h0 + 2) chk("contention_hdr_gap", hdr_cyc[h0 + 1] - hdr_cyc[h0], 6);

        // Zero-length request on requester 1 is dropped.
        d0 = drop_cnt; h0 = hdr_cyc.size(); t0 = tx_cnt; g0 = grant_log.size();
        push(1, 96'hDEAD, 0, 8'h00);
        run_idle(20, "zero_len");
        chk("zero_drop", drop_cnt - d0, 1);
        chk("zero_no_header", hdr_cyc.size() - h0, 0);
        chk("zero_no_write", tx_cnt - t0, 0);
        chk("zero_req_ready_count", grant_log.size() - g0, 1);
        if (grant_log.size() > g0) chk("zero_req_ready_owner", grant_log[g0], 1);

        // Reset after three of eight bytes, then a fresh frame.
        t0 = tx_cnt;
        push(0, 96'hE0, 8, 8'hE0);
        n = 0;
        while (tx_cnt - t0 < 3 && n < 40) begin tick(); n++; end
        chk("reset_mid_three_bytes", tx_cnt - t0, 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("midreset_busy", s_busy, 1'b0);
        chk("midreset_grant_id", s_grant, 0);
        chk("midreset_header", {s_haddr, s_nob}, 0);
        chk("midreset_strobes", {s_rxhv, s_txv, s_drop, s_sr, s_rr}, 0);
        t0 = tx_log.size(); g0 = grant_log.size();
        push(1, 96'hF0, 2, 8'hF0);
        run_idle(40, "after_reset");
        if (grant_log.size() > g0) chk("after_reset_owner", grant_log[g0], 1);
        chk("after_reset_writes", tx_log.size() - t0, 2);
        if (tx_log.size() >= t0 + 2) chk("after_reset_bytes", {tx_log[t0], tx_log[t0 + 1]}, 16'hF0F1);

        // Randomized traffic against the model.
        rnd = 1'b1; sum = 0; zlen = 0; t0 = tx_cnt; d0 = drop_cnt;
        for (int f = 0; f < 60; f++) begin
            r   = $urandom_range(N - 1);
            len = $urandom_range(20);
            if (len == 0) zlen++;
            sum += len;
            push(r, {$urandom, $urandom, $urandom}, len, 8'($urandom));
            k = $urandom_range(12);
            repeat (k) tick();
        end
        run_idle(6000, "random");
        rnd = 1'b0;
        chk("random_total_bytes", tx_cnt - t0, sum);
        chk("random_drops", drop_cnt - d0, zlen);

        // Maximum length frame.
        t0 = tx_log.size(); drain_delay = 2;
        push(0, 96'hFFFF, 65535, 8'h00);
        run_idle(66000, "max_len");
        chk("max_writes", tx_log.size() - t0, 65535);
        if (tx_log.size() >= t0 + 65535) begin
            chk("max_last_byte", tx_log[t0 + 65534], 8'hFE);
            chk("max_contiguous", tx_cyc[t0 + 65534] - tx_cyc[t0], 65534);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
